// File: rtl/silife_gen_ctrl.sv
// silife_gen_ctrl: Wishbone register block and generation sequencer
// for the silife matrix (free-run, single-step and bounded-run modes).
module silife_gen_ctrl #(
   parameter int WIDTH = 8,
   parameter int HEIGHT = 8,
   parameter int DIV_WIDTH = 16,
   parameter logic [15:0] SCAN_RESET = 16'd3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_wb_cyc,
   input  logic                    i_wb_stb,
   input  logic                    i_wb_we,
   input  logic [31:0]             i_wb_addr,
   input  logic [31:0]             i_wb_data,
   output logic                    o_wb_ack,
   output logic [31:0]             o_wb_data,
   output logic                    matrix_select,
   input  logic                    matrix_ack,
   input  logic [31:0]             matrix_data,
   output logic                    gen_tick,
   output logic                    invert,
   output logic [15:0]             scan_cycles,
   output logic                    irq,
   output logic [WIDTH+HEIGHT-1:0] io_oeb
);

   typedef enum logic [1:0] {IDLE, FREE, BOUNDED} state_t;

   state_t state, state_next;

   logic                 ack, served, we_q;
   logic [5:0]           sel, sel_q;
   logic [31:0]          wdata_q, rdata, rdata_q;
   logic                 enable, irq_en, done, step_q;
   logic [31:0]          gen_count, step_remain;
   logic [DIV_WIDTH-1:0] tick_div, div_act, prescaler;
   logic                 req, run_tick, done_set;
   logic                 wr_ctrl, wr_status, wr_gen;
   logic                 wr_step, wr_div, wr_scan;
   logic                 unused_addr;

   assign matrix_select = i_wb_addr[23:12] == 12'h001;
   assign unused_addr = ^i_wb_addr[31:24];
   // served blocks a second ack while the master keeps stb high
   assign req = i_wb_cyc & i_wb_stb & ~matrix_select & ~ack & ~served;
   assign o_wb_ack = ack | (matrix_select & matrix_ack);
   assign o_wb_data = matrix_select ? matrix_data : rdata_q;
   assign io_oeb = '0;
   assign irq = done & irq_en;

   assign wr_ctrl = ack & we_q & sel_q[0];
   assign wr_status = ack & we_q & sel_q[1];
   assign wr_gen = ack & we_q & sel_q[2];
   assign wr_step = ack & we_q & sel_q[3];
   assign wr_div = ack & we_q & sel_q[4];
   assign wr_scan = ack & we_q & sel_q[5];

   assign run_tick = (state != IDLE) && (prescaler == div_act);
   assign gen_tick = run_tick | step_q;

   always_comb begin
      sel = '0;
      if (i_wb_addr[23:5] == '0 && i_wb_addr[1:0] == 2'b00) begin
         case (i_wb_addr[4:2])
            3'd0: sel[0] = 1'b1;
            3'd1: sel[1] = 1'b1;
            3'd2: sel[2] = 1'b1;
            3'd3: sel[3] = 1'b1;
            3'd4: sel[4] = 1'b1;
            3'd5: sel[5] = 1'b1;
            default: sel = '0;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         sel[0]: rdata = {28'd0, irq_en, 1'b0, invert, enable};
         sel[1]: rdata = {30'd0, done, state != IDLE};
         sel[2]: rdata = gen_count;
         sel[3]: rdata = step_remain;
         sel[4]: rdata = 32'(tick_div);
         sel[5]: rdata = {16'd0, scan_cycles};
         default: rdata = '0;
      endcase
   end

   always_comb begin
      state_next = state;
      done_set = 1'b0;
      if (wr_step) begin
         state_next = (wdata_q == '0) ? IDLE : BOUNDED;
      end else begin
         case (state)
            IDLE: if (wr_ctrl && wdata_q[0]) state_next = FREE;
            FREE: if (wr_ctrl && !wdata_q[0]) state_next = IDLE;
            BOUNDED: begin
               if (run_tick && step_remain == 32'd1) begin
                  state_next = IDLE;
                  done_set = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_next;
   end

   // write side effects are applied at the end of the ack cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack <= 1'b0;
         served <= 1'b0;
         we_q <= 1'b0;
         sel_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         ack <= req;
         served <= i_wb_cyc & i_wb_stb & (served | ack);
         if (req) begin
            we_q <= i_wb_we;
            sel_q <= sel;
            wdata_q <= i_wb_data;
            rdata_q <= rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable <= 1'b0;
         invert <= 1'b0;
         irq_en <= 1'b0;
         step_q <= 1'b0;
         done <= 1'b0;
         tick_div <= '0;
         scan_cycles <= SCAN_RESET;
      end else begin
         step_q <= wr_ctrl & wdata_q[2] & (state == IDLE);
         if (wr_ctrl) begin
            enable <= wdata_q[0];
            invert <= wdata_q[1];
            irq_en <= wdata_q[3];
         end
         if (wr_div) tick_div <= wdata_q[DIV_WIDTH-1:0];
         if (wr_scan) scan_cycles <= wdata_q[15:0];
         if (done_set) done <= 1'b1;
         else if (wr_status && wdata_q[1]) done <= 1'b0;
      end
   end

   // div_act holds the divider in use; new TICK_DIV lands at a wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gen_count <= '0;
         step_remain <= '0;
         prescaler <= '0;
         div_act <= '0;
      end else begin
         if (wr_gen) gen_count <= wdata_q;
         else if (gen_tick) gen_count <= gen_count + 32'd1;
         if (wr_step) step_remain <= wdata_q;
         else if (run_tick && state == BOUNDED)
            step_remain <= step_remain - 32'd1;
         if (state == IDLE || state_next == IDLE || run_tick)
            prescaler <= '0;
         else
            prescaler <= prescaler + DIV_WIDTH'(1);
         if (state == IDLE || run_tick) div_act <= tick_div;
      end
   end

endmodule
